// File: rtl/bus_ram.sv
// Word-addressed RAM slave behind a valid/ready request bus with a fixed
// response latency, a byte-lane write mask and an out-of-window error flag.
//
// state  | meaning
// S_IDLE | waiting for a request; mem_valid accepted here
// S_WAIT | counting down wait cycles; mem_valid low aborts
// S_RESP | one-cycle response; write commits at the closing edge
module bus_ram #(
   parameter int          WORDS = 1024,
   parameter int          WAIT  = 1,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        err
);

   localparam int          AW        = $clog2(WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
   localparam logic [31:0] WORDS_W   = 32'(WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        do_write;

   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;

   logic [31:0] ram [WORDS] = '{default: 32'h0};

   logic [31:0] offset;
   logic        in_win;
   logic [AW-1:0] word_idx;
   logic        resp;

   // Window decode always works from the captured request, never the live bus.
   assign offset   = req_addr - BASE;
   assign in_win   = (req_addr >= BASE) && ((offset >> 2) < WORDS_W);
   assign word_idx = offset[AW+1:2];
   assign resp     = (state == S_RESP);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      do_write  = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_valid) begin
               accept = 1'b1;
               if (WAIT > 0) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end else begin
                  state_nxt = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (!mem_valid) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nxt = S_RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
            do_write  = mem_valid && in_win && (req_wstrb != 4'b0000);
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && accept) begin
         req_addr  <= mem_addr;
         req_wdata <= mem_wdata;
         req_wstrb <= mem_wstrb;
      end
   end

   // RAM has no reset; a reset edge also suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (rstn && do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (req_wstrb[i]) begin
               ram[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_ready = resp;
   assign err       = resp && !in_win;
   assign mem_rdata = (resp && in_win) ? ram[word_idx] : 32'h0;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: three instances (WAIT=2 default window, WAIT=0, and a
// small offset window) checked against a word-array model of the RAM.
module tb_bus_ram;

   logic clk = 1'b0;
   logic rstn;
   logic [2:0]       vld, rdy, er;
   logic [2:0][31:0] adr, wdt, rdt;
   logic [2:0][3:0]  wsb;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mod_a [1024];
   logic [31:0] mod_b [1024];
   logic [31:0] mod_c [16];

   bus_ram #(.WORDS(1024), .WAIT(2), .BASE(32'h0)) dut_a (
      .clk(clk), .rstn(rstn), .mem_valid(vld[0]), .mem_ready(rdy[0]),
      .mem_addr(adr[0]), .mem_wdata(wdt[0]), .mem_wstrb(wsb[0]),
      .mem_rdata(rdt[0]), .err(er[0]));

   bus_ram #(.WORDS(1024), .WAIT(0), .BASE(32'h0)) dut_b (
      .clk(clk), .rstn(rstn), .mem_valid(vld[1]), .mem_ready(rdy[1]),
      .mem_addr(adr[1]), .mem_wdata(wdt[1]), .mem_wstrb(wsb[1]),
      .mem_rdata(rdt[1]), .err(er[1]));

   bus_ram #(.WORDS(16), .WAIT(1), .BASE(32'h100)) dut_c (
      .clk(clk), .rstn(rstn), .mem_valid(vld[2]), .mem_ready(rdy[2]),
      .mem_addr(adr[2]), .mem_wdata(wdt[2]), .mem_wstrb(wsb[2]),
      .mem_rdata(rdt[2]), .err(er[2]));

   always #5 clk = ~clk;

   function automatic int wt_of(input int d);
      return (d == 0) ? 2 : (d == 1) ? 0 : 1;
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 2) ? 32'h100 : 32'h0;
   endfunction

   function automatic longint words_of(input int d);
      return (d == 2) ? 64'd16 : 64'd1024;
   endfunction

   function automatic logic [31:0] mod_get(input int d, input int idx);
      case (d)
         0:       return mod_a[idx];
         1:       return mod_b[idx];
         default: return mod_c[idx];
      endcase
   endfunction

   task automatic mod_put(input int d, input int idx, input logic [31:0] v);
      case (d)
         0:       mod_a[idx] = v;
         1:       mod_b[idx] = v;
         default: mod_c[idx] = v;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered just after a rising edge with the DUT idle; leaves it the same way.
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s, input bit hold_resp,
                      output logic [31:0] got, output logic got_err);
      int          wt;
      bit          inw;
      int          idx;
      logic [31:0] exp_rd, nw;
      wt  = wt_of(d);
      inw = (a >= base_of(d)) && ((longint'(a - base_of(d)) >> 2) < words_of(d));
      idx = inw ? int'((a - base_of(d)) >> 2) : 0;
      exp_rd = inw ? mod_get(d, idx) : 32'h0;
      got = 32'h0;
      got_err = 1'b0;
      vld[d] = 1'b1; adr[d] = a; wdt[d] = w; wsb[d] = s;
      for (int n = 0; n <= wt + 1; n++) begin
         @(negedge clk);
         chk($sformatf("d%0d a=%h ready c%0d", d, a, n), {31'b0, rdy[d]}, 32'(n == wt + 1));
         if (n == wt + 1) begin
            got = rdt[d];
            got_err = er[d];
            chk($sformatf("d%0d a=%h rdata", d, a), rdt[d], exp_rd);
            chk($sformatf("d%0d a=%h err", d, a), {31'b0, er[d]}, 32'(!inw));
         end else begin
            chk($sformatf("d%0d a=%h idle rdata c%0d", d, a, n), rdt[d], 32'h0);
            chk($sformatf("d%0d a=%h idle err c%0d", d, a, n), {31'b0, er[d]}, 32'h0);
         end
         @(posedge clk); #1;
         if (n == 0) begin
            adr[d] = $urandom; wdt[d] = $urandom; wsb[d] = 4'($urandom);
         end
         if (n == wt && !hold_resp) vld[d] = 1'b0;
      end
      vld[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("d%0d a=%h ready after", d, a), {31'b0, rdy[d]}, 32'h0);
      @(posedge clk); #1;
      if (inw && s != 4'b0000 && hold_resp) begin
         nw = mod_get(d, idx);
         for (int i = 0; i < 4; i++) if (s[i]) nw[8*i +: 8] = w[8*i +: 8];
         mod_put(d, idx, nw);
      end
   endtask

   initial begin
      logic [31:0] got;
      logic        ge;
      logic [31:0] ra;
      logic [3:0]  rs;

      for (int i = 0; i < 1024; i++) begin mod_a[i] = '0; mod_b[i] = '0; end
      for (int i = 0; i < 16; i++) mod_c[i] = '0;
      rstn = 1'b0; vld = '0; adr = '0; wdt = '0; wsb = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset ready d%0d", d), {31'b0, rdy[d]}, 32'h0);
         chk($sformatf("reset err d%0d", d), {31'b0, er[d]}, 32'h0);
         chk($sformatf("reset rdata d%0d", d), rdt[d], 32'h0);
      end
      @(posedge clk); #1;
      rstn = 1'b1;

      // full write, read back, byte-lane write
      txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, got, ge);
      chk("w10 pre-write rdata", got, 32'h0);
      txn(0, 32'h10, 32'h0, 4'h0, 1'b1, got, ge);
      chk("r10 full", got, 32'hDEADBEEF);
      chk("r10 err", {31'b0, ge}, 32'h0);
      txn(0, 32'h11, 32'h0000AA00, 4'b0010, 1'b1, got, ge);
      chk("w11 pre-write rdata", got, 32'hDEADBEEF);
      txn(0, 32'h10, 32'h0, 4'h0, 1'b1, got, ge);
      chk("r10 byte", got, 32'hDEADAAEF);

      // out of window
      txn(0, 32'h1000, 32'h0, 4'h0, 1'b1, got, ge);
      chk("oow read rdata", got, 32'h0);
      chk("oow read err", {31'b0, ge}, 32'h1);
      txn(0, 32'h1000, 32'h12345678, 4'hF, 1'b1, got, ge);
      txn(0, 32'h0, 32'h0, 4'h0, 1'b1, got, ge);
      chk("oow write dropped", got, 32'h0);

      // abort in WAIT
      vld[0] = 1'b1; adr[0] = 32'h20; wdt[0] = 32'hCAFEF00D; wsb[0] = 4'hF;
      @(negedge clk);
      chk("abort ready c0", {31'b0, rdy[0]}, 32'h0);
      @(posedge clk); #1;
      vld[0] = 1'b0;
      for (int n = 1; n < 6; n++) begin
         @(negedge clk);
         chk($sformatf("abort ready c%0d", n), {31'b0, rdy[0]}, 32'h0);
         @(posedge clk); #1;
      end
      txn(0, 32'h20, 32'h0, 4'h0, 1'b1, got, ge);
      chk("abort no write", got, 32'h0);

      // valid dropped in RESP: no commit
      txn(0, 32'h40, 32'h11111111, 4'hF, 1'b0, got, ge);
      txn(0, 32'h40, 32'h0, 4'h0, 1'b1, got, ge);
      chk("resp drop no write", got, 32'h0);

      // reset during WAIT
      vld[0] = 1'b1; adr[0] = 32'h30; wdt[0] = 32'h55AA55AA; wsb[0] = 4'hF;
      @(negedge clk);
      chk("rstwait ready c0", {31'b0, rdy[0]}, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(negedge clk);
      chk("rstwait ready c1", {31'b0, rdy[0]}, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1; vld[0] = 1'b0;
      for (int n = 2; n < 6; n++) begin
         @(negedge clk);
         chk($sformatf("rstwait ready c%0d", n), {31'b0, rdy[0]}, 32'h0);
         @(posedge clk); #1;
      end
      txn(0, 32'h30, 32'h0, 4'h0, 1'b1, got, ge);
      chk("rstwait no write", got, 32'h0);
      txn(0, 32'h10, 32'h0, 4'h0, 1'b1, got, ge);
      chk("rstwait ram kept", got, 32'hDEADAAEF);

      // valid held through reset is accepted on the first cycle after release
      rstn = 1'b0; vld[0] = 1'b1; adr[0] = 32'h10; wsb[0] = 4'h0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk($sformatf("valid in reset ready %0d", n), {31'b0, rdy[0]}, 32'h0);
         @(posedge clk); #1;
      end
      rstn = 1'b1;
      txn(0, 32'h10, 32'h0, 4'h0, 1'b1, got, ge);
      chk("post-release read", got, 32'hDEADAAEF);

      // WAIT=0 back-to-back reads with valid held high
      txn(1, 32'h8, 32'hA5A5A5A5, 4'hF, 1'b1, got, ge);
      vld[1] = 1'b1; adr[1] = 32'h8; wsb[1] = 4'h0; wdt[1] = 32'h0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk($sformatf("b2b ready c%0d", n), {31'b0, rdy[1]}, 32'(n == 1 || n == 3));
         chk($sformatf("b2b rdata c%0d", n), rdt[1], (n == 1 || n == 3) ? 32'hA5A5A5A5 : 32'h0);
         @(posedge clk); #1;
         if (n == 3) vld[1] = 1'b0;
      end

      // random traffic against the model
      for (int k = 0; k < 60; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(32'hE0, 32'h160));
         rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         txn(2, ra, $urandom, rs, $urandom_range(0, 7) != 0, got, ge);
      end
      for (int k = 0; k < 30; k++) begin
         ra = 32'($urandom_range(0, 32'h1010));
         rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         txn(0, ra, $urandom, rs, 1'b1, got, ge);
      end
      for (int k = 0; k < 20; k++) begin
         ra = 32'($urandom_range(0, 32'h100));
         rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         txn(1, ra, $urandom, rs, 1'b1, got, ge);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
